// File: rtl/irq_ctrl.sv
// =============================================================================
// irq_ctrl -- interrupt and timer controller
//
// Collects NUM_SRC asynchronous interrupt lines (per-source enable and
// level/edge mode), arbitrates them lowest-index-first, and presents a
// registered EXT_IRQ/EXT_ID pair with a claim/complete handshake. It also
// holds a 64-bit mtime/mtimecmp timer that drives TIMER_IRQ.
//
// Optional feature: define SOFT_IRQ_EN to add the MSIP register at address 6
// and the SW_IRQ output. Without it, address 6 reads 0 and ignores writes.
//
// Ports:
//   CLK        in   core clock
//   RESET      in   asynchronous active-low reset
//   SRC_IRQ    in   [NUM_SRC] raw asynchronous interrupt lines
//   CFG_WE     in   register write strobe
//   CFG_ADDR   in   [3] register index
//   CFG_WDATA  in   [64] write data
//   CFG_RDATA  out  [64] registered read data (value sampled on previous edge)
//   CLAIM      in   pulse: trap taken for EXT_ID
//   COMPLETE   in   pulse: handler finished
//   EXT_IRQ    out  external interrupt request
//   EXT_ID     out  [ID_W] index of the requesting source
//   TIMER_IRQ  out  timer interrupt request (mtime >= mtimecmp)
//   SW_IRQ     out  software interrupt (SOFT_IRQ_EN only)
//
// Register map (CFG_ADDR):
//   0 ENABLE   1 MODE (1 = edge)   2 PENDING (W1C)   3 MTIME   4 MTIMECMP
//   5 CLAIM_ID {in_service, EXT_ID} (read-only)
//   6 MSIP (SOFT_IRQ_EN) / reserved   7 reserved
// =============================================================================
`default_nettype none

module irq_ctrl #(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TICK_DIV    = 1,
    parameter int ID_W        = $clog2(NUM_SRC)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_SRC-1:0] SRC_IRQ,
    input  logic               CFG_WE,
    input  logic [2:0]         CFG_ADDR,
    input  logic [63:0]        CFG_WDATA,
    output logic [63:0]        CFG_RDATA,
    input  logic               CLAIM,
    input  logic               COMPLETE,
    output logic               EXT_IRQ,
    output logic [ID_W-1:0]    EXT_ID,
    output logic               TIMER_IRQ
`ifdef SOFT_IRQ_EN
    ,
    output logic               SW_IRQ
`endif
);

    localparam logic [2:0] ADDR_ENABLE   = 3'd0;
    localparam logic [2:0] ADDR_MODE     = 3'd1;
    localparam logic [2:0] ADDR_PENDING  = 3'd2;
    localparam logic [2:0] ADDR_MTIME    = 3'd3;
    localparam logic [2:0] ADDR_MTIMECMP = 3'd4;
    localparam logic [2:0] ADDR_CLAIM_ID = 3'd5;
`ifdef SOFT_IRQ_EN
    localparam logic [2:0] ADDR_MSIP     = 3'd6;
`endif

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NUM_SRC-1:0] sync_p [SYNC_STAGES];
    logic [NUM_SRC-1:0] sync_prev;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] mode;
    logic [NUM_SRC-1:0] pending;
    logic               in_service;
    logic [63:0]        mtime;
    logic [63:0]        mtimecmp;
    logic [TICK_W-1:0]  tick_cnt;
`ifdef SOFT_IRQ_EN
    logic               msip;
`endif

    // -------------------------------------------------------------------------
    // Combinational next-state
    // -------------------------------------------------------------------------
    logic [NUM_SRC-1:0] sync;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] claim_clr;
    logic [NUM_SRC-1:0] edge_next;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] cand;
    logic               win_vld;
    logic [ID_W-1:0]    win_id;
    logic               claim_ok;
    logic               in_service_next;
    logic               tick_wrap;
    logic               mtime_we;
    logic [63:0]        rd_val;

    assign sync = sync_p[SYNC_STAGES-1];
    assign rise = sync & ~sync_prev;
    assign w1c  = (CFG_WE && CFG_ADDR == ADDR_PENDING) ? CFG_WDATA[NUM_SRC-1:0] : '0;

    // EXT_IRQ high implies in_service is clear, so a claim is only honoured
    // when a request is actually being presented.
    assign claim_ok  = CLAIM && EXT_IRQ;
    assign claim_clr = claim_ok ? (NUM_SRC'(1) << EXT_ID) : '0;

    // Edge sources: a new rise beats any clear arriving in the same cycle.
    assign edge_next    = rise | (pending & ~(w1c | claim_clr));
    assign pending_next = (mode & edge_next) | (~mode & sync);

    // COMPLETE is applied before CLAIM.
    assign in_service_next = (in_service && !COMPLETE) || claim_ok;

    assign cand = pending & enable;

    always_comb begin
        win_vld = |cand;
        win_id  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    assign tick_wrap = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign mtime_we  = CFG_WE && (CFG_ADDR == ADDR_MTIME);

    always_comb begin
        rd_val = '0;
        case (CFG_ADDR)
            ADDR_ENABLE:   rd_val[NUM_SRC-1:0] = enable;
            ADDR_MODE:     rd_val[NUM_SRC-1:0] = mode;
            ADDR_PENDING:  rd_val[NUM_SRC-1:0] = pending;
            ADDR_MTIME:    rd_val              = mtime;
            ADDR_MTIMECMP: rd_val              = mtimecmp;
            ADDR_CLAIM_ID: rd_val[ID_W:0]      = {in_service, EXT_ID};
`ifdef SOFT_IRQ_EN
            ADDR_MSIP:     rd_val[0]           = msip;
`endif
            default:       rd_val              = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Stage p0..pN: input synchroniser chain, then edge-detect history
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_p[s] <= '0;
            end
            sync_prev <= '0;
        end else begin
            sync_p[0] <= SRC_IRQ;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_p[s] <= sync_p[s-1];
            end
            sync_prev <= sync;
        end
    end

    // -------------------------------------------------------------------------
    // Stage: configuration, pending and claim state
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            enable     <= '0;
            mode       <= '0;
            pending    <= '0;
            in_service <= 1'b0;
        end else begin
            if (CFG_WE && CFG_ADDR == ADDR_ENABLE) begin
                enable <= CFG_WDATA[NUM_SRC-1:0];
            end
            if (CFG_WE && CFG_ADDR == ADDR_MODE) begin
                mode <= CFG_WDATA[NUM_SRC-1:0];
            end
            pending    <= pending_next;
            in_service <= in_service_next;
        end
    end

    // -------------------------------------------------------------------------
    // Stage: registered arbiter outputs
    // -------------------------------------------------------------------------
    // EXT_ID is frozen while a claim is in service, so it doubles as the
    // latched claimed ID reported through CLAIM_ID.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            EXT_IRQ <= 1'b0;
            EXT_ID  <= '0;
        end else begin
            EXT_IRQ <= win_vld && !in_service_next;
            if (win_vld && !in_service_next) begin
                EXT_ID <= win_id;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage: timer
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            tick_cnt  <= '0;
            TIMER_IRQ <= 1'b0;
        end else begin
            if (mtime_we) begin
                mtime    <= CFG_WDATA;
                tick_cnt <= '0;
            end else if (tick_wrap) begin
                mtime    <= mtime + 64'd1;
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
            if (CFG_WE && CFG_ADDR == ADDR_MTIMECMP) begin
                mtimecmp <= CFG_WDATA;
            end
            TIMER_IRQ <= (mtime >= mtimecmp);
        end
    end

    // -------------------------------------------------------------------------
    // Stage: read data register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            CFG_RDATA <= '0;
        end else begin
            CFG_RDATA <= rd_val;
        end
    end

`ifdef SOFT_IRQ_EN
    // -------------------------------------------------------------------------
    // Stage: software interrupt
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            msip   <= 1'b0;
            SW_IRQ <= 1'b0;
        end else begin
            if (CFG_WE && CFG_ADDR == ADDR_MSIP) begin
                msip <= CFG_WDATA[0];
            end
            SW_IRQ <= msip;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// Directed testbench for irq_ctrl (default parameters: NUM_SRC=8,
// SYNC_STAGES=2, TICK_DIV=1). Inputs change 1 time unit after a rising edge
// and outputs are sampled at the same point.
module tb_irq_ctrl;

    localparam int NUM_SRC = 8;
    localparam int ID_W    = 3;
    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic               CLK = 1'b0;
    logic               RESET;
    logic [NUM_SRC-1:0] SRC_IRQ;
    logic               CFG_WE;
    logic [2:0]         CFG_ADDR;
    logic [63:0]        CFG_WDATA;
    logic [63:0]        CFG_RDATA;
    logic               CLAIM;
    logic               COMPLETE;
    logic               EXT_IRQ;
    logic [ID_W-1:0]    EXT_ID;
    logic               TIMER_IRQ;
`ifdef SOFT_IRQ_EN
    logic               SW_IRQ;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    irq_ctrl #(
        .NUM_SRC     (NUM_SRC),
        .SYNC_STAGES (2),
        .TICK_DIV    (1)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .SRC_IRQ   (SRC_IRQ),
        .CFG_WE    (CFG_WE),
        .CFG_ADDR  (CFG_ADDR),
        .CFG_WDATA (CFG_WDATA),
        .CFG_RDATA (CFG_RDATA),
        .CLAIM     (CLAIM),
        .COMPLETE  (COMPLETE),
        .EXT_IRQ   (EXT_IRQ),
        .EXT_ID    (EXT_ID),
        .TIMER_IRQ (TIMER_IRQ)
`ifdef SOFT_IRQ_EN
        ,
        .SW_IRQ    (SW_IRQ)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [63:0] d);
        CFG_WE    = 1'b1;
        CFG_ADDR  = a;
        CFG_WDATA = d;
        tick(1);
        CFG_WE    = 1'b0;
    endtask

    initial begin
        SRC_IRQ   = '0;
        CFG_WE    = 1'b0;
        CFG_ADDR  = 3'd0;
        CFG_WDATA = '0;
        CLAIM     = 1'b0;
        COMPLETE  = 1'b0;
        RESET     = 1'b1;
        #2 RESET  = 1'b0;
        #1;
        check("rst_ext_irq", EXT_IRQ, 0);
        check("rst_ext_id", EXT_ID, 0);
        check("rst_timer_irq", TIMER_IRQ, 0);
        check("rst_rdata", CFG_RDATA, 0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        tick(1);

        // ---- reset in the middle of operation ----
        wr(3'd0, 64'h03);
        wr(3'd3, 64'h55);
        wr(3'd4, 64'h0);
        SRC_IRQ = 8'h03;
        tick(4);
        CFG_ADDR = 3'd2;
        tick(1);
        check("pre_rst_pending", CFG_RDATA, 64'h3);
        check("pre_rst_ext_irq", EXT_IRQ, 1);
        check("pre_rst_timer", TIMER_IRQ, 1);
        CFG_ADDR = 3'd3;
        tick(1);
        #2 RESET = 1'b0;
        #1;
        check("mid_rst_ext_irq", EXT_IRQ, 0);
        check("mid_rst_ext_id", EXT_ID, 0);
        check("mid_rst_timer", TIMER_IRQ, 0);
        check("mid_rst_rdata", CFG_RDATA, 0);
        SRC_IRQ = '0;
        @(negedge CLK);
        RESET = 1'b1;
        tick(1);
        check("post_rst_mtime", CFG_RDATA, 0);
        CFG_ADDR = 3'd4;
        tick(1);
        check("post_rst_mtimecmp", CFG_RDATA, ALL_ONES);
        CFG_ADDR = 3'd2;
        tick(1);
        check("post_rst_pending", CFG_RDATA, 0);

        // ---- priority, level mode ----
        wr(3'd0, 64'hFF);
        SRC_IRQ = 8'h28;
        tick(3);
        check("prio_lat3_irq", EXT_IRQ, 0);
        tick(1);
        check("prio_lat4_irq", EXT_IRQ, 1);
        check("prio_id3", EXT_ID, 3);
        SRC_IRQ = 8'h20;
        tick(4);
        check("prio_id5", EXT_ID, 5);
        check("prio_id5_irq", EXT_IRQ, 1);
        SRC_IRQ = 8'h00;
        tick(4);
        check("prio_idle_irq", EXT_IRQ, 0);
        check("prio_idle_id_hold", EXT_ID, 5);

        // ---- edge mode, claim / complete ----
        wr(3'd1, 64'h01);
        CFG_ADDR = 3'd2;
        SRC_IRQ  = 8'h01;
        tick(1);
        SRC_IRQ  = 8'h00;
        tick(3);
        check("edge_irq", EXT_IRQ, 1);
        check("edge_id", EXT_ID, 0);
        check("edge_pending", CFG_RDATA, 64'h1);
        CLAIM = 1'b1;
        tick(1);
        CLAIM = 1'b0;
        check("claim_mask", EXT_IRQ, 0);
        tick(1);
        check("claim_pending_clr", CFG_RDATA, 0);
        CFG_ADDR = 3'd5;
        tick(1);
        check("claim_id", CFG_RDATA, 64'h8);
        SRC_IRQ = 8'h01;
        tick(1);
        SRC_IRQ = 8'h00;
        tick(5);
        check("in_service_mask", EXT_IRQ, 0);
        CFG_ADDR = 3'd2;
        tick(1);
        check("in_service_pending", CFG_RDATA, 64'h1);
        check("pre_complete_irq", EXT_IRQ, 0);
        COMPLETE = 1'b1;
        tick(1);
        COMPLETE = 1'b0;
        check("complete_reassert", EXT_IRQ, 1);
        CLAIM = 1'b1;
        tick(1);
        CLAIM    = 1'b0;
        COMPLETE = 1'b1;
        tick(1);
        COMPLETE = 1'b0;
        check("complete_idle_irq", EXT_IRQ, 0);
        CFG_ADDR = 3'd5;
        tick(1);
        check("complete_claim_id", CFG_RDATA, 0);
        CLAIM = 1'b1;
        tick(1);
        CLAIM = 1'b0;
        tick(1);
        check("stray_claim", CFG_RDATA, 0);

        // ---- set wins over W1C ----
        wr(3'd1, 64'h05);
        CFG_ADDR = 3'd2;
        SRC_IRQ  = 8'h04;
        tick(1);
        SRC_IRQ  = 8'h00;
        tick(3);
        check("src2_pending", CFG_RDATA, 64'h4);
        wr(3'd2, 64'h4);
        tick(1);
        check("w1c_clear", CFG_RDATA, 0);
        SRC_IRQ = 8'h04;
        tick(1);
        SRC_IRQ = 8'h00;
        tick(1);
        wr(3'd2, 64'h4);
        tick(1);
        check("set_wins", CFG_RDATA, 64'h4);
        wr(3'd2, 64'h4);
        wr(3'd1, 64'h00);

        // ---- timer compare ----
        wr(3'd3, 64'd0);
        wr(3'd4, 64'd10);
        tick(9);
        check("timer_before", TIMER_IRQ, 0);
        tick(1);
        check("timer_rise", TIMER_IRQ, 1);
        CFG_ADDR = 3'd3;
        tick(1);
        check("timer_mtime11", CFG_RDATA, 64'd11);
        wr(3'd4, 64'h1000);
        check("timer_hold", TIMER_IRQ, 1);
        tick(1);
        check("timer_cmp_raise", TIMER_IRQ, 0);

        // ---- timer wrap ----
        wr(3'd4, ALL_ONES);
        wr(3'd3, ALL_ONES);
        tick(1);
        check("wrap_irq_hi", TIMER_IRQ, 1);
        tick(1);
        check("wrap_irq_lo", TIMER_IRQ, 0);
        check("wrap_mtime0", CFG_RDATA, 0);

        // ---- software interrupt / reserved ----
        wr(3'd6, 64'h1);
        tick(1);
`ifdef SOFT_IRQ_EN
        check("sw_irq", SW_IRQ, 1);
        check("msip_read", CFG_RDATA, 64'h1);
`else
        check("addr6_read", CFG_RDATA, 0);
`endif
        wr(3'd7, ALL_ONES);
        tick(1);
        check("addr7_read", CFG_RDATA, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
